exp_align_pipe: RTL and testbench
=================================

Name: exp_align_pipe

Overview:
- Stage directly downstream of the 9-input max-exponent determination in the MAC subsystem.
- Takes the 9 FP16 product terms of a 3x3 window (sign, 6-bit exponent, 22-bit product mantissa, skip flag), finds the common maximum exponent and right-aligns every mantissa to it.
- Output is 9 signed fixed-point lanes ready for the adder tree, plus the shared exponent.
- 2-stage elastic pipeline with valid/ready backpressure.

Parameters:
- EXP_W, 6, exponent width per lane (FP16 exp plus carry bit).
- MAN_W, 22, product mantissa width, hidden bits included.
- GRD_W, 3, guard bits appended below the mantissa before shifting.
- N_LANE, 9, number of terms; fixed at 9, other values unsupported.

Ports:
- clk, input, 1, clock; all state on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, stage can accept a beat.
- in_skip, input, 9, lane skip; bit 8 = lane 1 ... bit 0 = lane 9.
- in_sign, input, 9, lane sign, same bit order.
- in_exp, input, 9*EXP_W, lane exponents; lane 1 in the MSB slice.
- in_man, input, 9*MAN_W, lane mantissas; lane 1 in the MSB slice.
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts the beat.
- out_max_exp, output, EXP_W, common exponent.
- out_aligned, output, 9*(MAN_W+GRD_W+1), two's-complement aligned lanes; lane 1 in the MSB slice.

Behaviour:
- Reset (async, rst=1): both stage valids = 0; all data registers = 0; out_valid = 0; out_max_exp = 0; out_aligned = 0. in_ready = 1 from the first cycle after reset deassertion.
- Handshake: a transfer occurs when valid and ready are both 1.
  - in_ready = !s1_valid | s1_advance.
  - s1_advance = !s2_valid | out_ready.
  - Output data stays stable while out_valid=1 and out_ready=0.
  - No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready only.
- Stage 1 (on input transfer):
  - Register the lane data with skipped lanes forced to exp=0, man=0, sign=0.
  - Register max_exp = unsigned max of the 9 forced exponents.
  - All lanes skipped -> max_exp = 0.
- Stage 2 (on stage-1 advance), per lane:
  - diff = max_exp - exp_i (always >= 0).
  - ext = {man_i, GRD_W zeros}, 25 bits.
  - mag = ext >> diff. The LSB of mag is ORed with the OR of all shifted-out bits (sticky).
  - diff >= MAN_W+GRD_W -> mag = 0, with LSB = 1 iff man_i != 0.
  - man_i = 0 -> mag = 0 regardless of diff.
  - aligned_i = sign_i ? -{0,mag} : {0,mag}, 26-bit two's complement. Negative zero is output as 0.
  - out_max_exp is registered alongside the lanes.
- Latency: 2 cycles, in_valid transfer to out_valid. Throughput: 1 beat/cycle while out_ready=1.
- Simultaneous events: when stage 2 is full and out_ready=1, a stage-2 drain, stage-1 advance and new input capture all happen in the same cycle with no bubble.
- Reset mid-operation: in-flight beats are discarded, nothing is replayed.

Decomposition:
- Shared package (mac_pkg): EXP_W, MAN_W, GRD_W, N_LANE, ALN_W = MAN_W+GRD_W+1, and a lane-slice index helper function.
- One natural sub-module: align_shift_lane (combinational: man, sign, diff -> aligned with sticky). Instantiate it 9 times in stage 2.
- The max tree stays inline in stage 1: 4 pairwise compares, then 2, then 1, then lane 9.

Test Plan:
- Aligned lanes: exps {15,13,15,15,15,15,15,15,15}, all man=0x200000, signs 0, skip=0, out_ready=1.
  - out_max_exp=15 two cycles later.
  - Lane 1 = 0x1000000; lane 2 = 0x0400000.
- Negation and sticky:
  - Lane 1: sign=1, man=0x200000, diff 0 -> 0x3000000.
  - Lane 3: man=0x000001, diff 5 -> 0x0000001.
  - Lane 4: man=0x3FFFFF, diff 30 -> 0x0000001.
- Skip: skip=9'h1FF with exps 20 -> out_max_exp=0, all lanes 0. Then skip=9'h100 with exp1=31, others 10 -> out_max_exp=10.
- Backpressure:
  - Stream 4 beats back-to-back; hold out_ready=0 for 3 cycles after the first output.
  - in_ready drops once both stages are full; output stays stable.
  - All 4 beats emerge in order with no loss or duplication.
- Reset mid-flight: assert rst while 2 beats are in flight -> out_valid=0 and all outputs 0 immediately (async). No stale beat appears after release.
- Randomised 10k beats against a reference model, with random in_valid/out_ready: bit-exact lanes and exponent.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and helpers for the MAC exponent-alignment datapath.
package mac_pkg;
  localparam int EXP_W  = 6;
  localparam int MAN_W  = 22;
  localparam int GRD_W  = 3;
  localparam int N_LANE = 9;
  localparam int EXT_W  = MAN_W + GRD_W;
  localparam int ALN_W  = MAN_W + GRD_W + 1;

  // Low bit of a lane's slice in a packed bus; lane index 0 is lane 1 (MSB slice).
  function automatic int lane_lo(input int lane, input int width);
    return (N_LANE - 1 - lane) * width;
  endfunction

  function automatic logic [EXP_W-1:0] exp_max(input logic [EXP_W-1:0] a,
                                               input logic [EXP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/exp_align_pipe_if.sv
// Input/output beat bundle of the exponent-alignment stage.
interface exp_align_pipe_if;
  import mac_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [N_LANE-1:0]         in_skip;
  logic [N_LANE-1:0]         in_sign;
  logic [N_LANE*EXP_W-1:0]   in_exp;
  logic [N_LANE*MAN_W-1:0]   in_man;
  logic                      out_valid;
  logic                      out_ready;
  logic [EXP_W-1:0]          out_max_exp;
  logic [N_LANE*ALN_W-1:0]   out_aligned;

  modport master (
    output in_valid, in_skip, in_sign, in_exp, in_man, out_ready,
    input  in_ready, out_valid, out_max_exp, out_aligned
  );

  modport slave (
    input  in_valid, in_skip, in_sign, in_exp, in_man, out_ready,
    output in_ready, out_valid, out_max_exp, out_aligned
  );
endinterface

// File: rtl/align_shift_lane.sv
// One lane of mantissa alignment: right shift with sticky, then sign apply.
module align_shift_lane
  import mac_pkg::*;
(
  input  logic [MAN_W-1:0] man,
  input  logic             sign,
  input  logic [EXP_W-1:0] diff,
  output logic [ALN_W-1:0] aligned
);
  logic [EXT_W-1:0] ext;
  logic [EXT_W-1:0] shifted;
  logic [EXT_W-1:0] lost_mask;
  logic             sticky;
  logic [ALN_W-1:0] mag;

  // Shifts of EXT_W or more leave shifted = 0 and a full lost mask, so the
  // result collapses to the sticky bit alone (set iff the mantissa is nonzero).
  always_comb begin
    ext       = {man, {GRD_W{1'b0}}};
    shifted   = ext >> diff;
    lost_mask = ~({EXT_W{1'b1}} << diff);
    sticky    = |(ext & lost_mask);
    mag       = {1'b0, shifted[EXT_W-1:1], shifted[0] | sticky};
    aligned   = sign ? -mag : mag;
  end
endmodule

// File: rtl/exp_align_pipe.sv
// Two-stage elastic pipeline: stage 1 registers skip-forced lanes and their
// max exponent, stage 2 registers the nine aligned two's-complement lanes.
module exp_align_pipe
  import mac_pkg::*;
(
  input logic             clk,
  input logic             rst,
  exp_align_pipe_if.slave bus
);
  logic              s1_valid;
  logic              s2_valid;
  logic              s1_advance;
  logic              in_fire;

  logic [EXP_W-1:0]  f_exp  [N_LANE];
  logic [MAN_W-1:0]  f_man  [N_LANE];
  logic [N_LANE-1:0] f_sign;
  logic [EXP_W-1:0]  max_l1 [4];
  logic [EXP_W-1:0]  max_l2 [2];
  logic [EXP_W-1:0]  max_l3;
  logic [EXP_W-1:0]  f_max;

  logic [EXP_W-1:0]  s1_exp [N_LANE];
  logic [MAN_W-1:0]  s1_man [N_LANE];
  logic [N_LANE-1:0] s1_sign;
  logic [EXP_W-1:0]  s1_max;

  logic [N_LANE*ALN_W-1:0] aligned_c;
  logic [N_LANE*ALN_W-1:0] s2_aligned;
  logic [EXP_W-1:0]        s2_max;

  assign s1_advance   = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_advance;
  assign in_fire      = bus.in_valid && bus.in_ready;

  // Unpack lanes; a skipped lane becomes an all-zero term.
  always_comb begin
    f_sign = '0;
    for (int i = 0; i < N_LANE; i++) begin
      f_exp[i] = '0;
      f_man[i] = '0;
      if (!bus.in_skip[N_LANE-1-i]) begin
        f_exp[i]  = bus.in_exp[lane_lo(i, EXP_W) +: EXP_W];
        f_man[i]  = bus.in_man[lane_lo(i, MAN_W) +: MAN_W];
        f_sign[i] = bus.in_sign[N_LANE-1-i];
      end
    end
  end

  // Max tree: four pairs, then two, then one, then the odd ninth lane.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      max_l1[i] = exp_max(f_exp[2*i], f_exp[2*i+1]);
    end
    max_l2[0] = exp_max(max_l1[0], max_l1[1]);
    max_l2[1] = exp_max(max_l1[2], max_l1[3]);
    max_l3    = exp_max(max_l2[0], max_l2[1]);
    f_max     = exp_max(max_l3, f_exp[N_LANE-1]);
  end

  // Stage 1 register: capture forced lanes and max exponent on input transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= '0;
      s1_max   <= '0;
      for (int i = 0; i < N_LANE; i++) begin
        s1_exp[i] <= '0;
        s1_man[i] <= '0;
      end
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_sign <= f_sign;
        s1_max  <= f_max;
        for (int i = 0; i < N_LANE; i++) begin
          s1_exp[i] <= f_exp[i];
          s1_man[i] <= f_man[i];
        end
      end
    end
  end

  for (genvar g = 0; g < N_LANE; g++) begin : g_lane
    localparam int LO = lane_lo(g, ALN_W);
    logic [EXP_W-1:0] diff;

    assign diff = s1_max - s1_exp[g];

    align_shift_lane u_lane (
      .man     (s1_man[g]),
      .sign    (s1_sign[g]),
      .diff    (diff),
      .aligned (aligned_c[LO +: ALN_W])
    );
  end

  // Stage 2 register: hold the aligned beat until downstream takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_max     <= '0;
      s2_aligned <= '0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_max     <= s1_max;
        s2_aligned <= aligned_c;
      end
    end
  end

  assign bus.out_valid   = s2_valid;
  assign bus.out_max_exp = s2_max;
  assign bus.out_aligned = s2_aligned;
endmodule

// File: tb/tb_exp_align_pipe.sv
// Self-checking bench for exp_align_pipe: directed cases with literal
// expectations plus randomized traffic against a behavioural model.
module tb_exp_align_pipe;
  import mac_pkg::*;

  localparam int OUT_W = N_LANE * ALN_W;
  localparam int IE_W  = N_LANE * EXP_W;
  localparam int IM_W  = N_LANE * MAN_W;

  logic clk = 1'b0;
  logic rst;

  exp_align_pipe_if bus ();

  exp_align_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  logic [OUT_W-1:0] exp_q  [$];
  logic [EXP_W-1:0] expe_q [$];

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [ALN_W-1:0] lane_of(input logic [OUT_W-1:0] v, input int lane);
    return v[(N_LANE-lane)*ALN_W +: ALN_W];
  endfunction

  function automatic logic [IE_W-1:0] put_e(input logic [IE_W-1:0] v, input int lane, input int val);
    v[(N_LANE-lane)*EXP_W +: EXP_W] = EXP_W'(val);
    return v;
  endfunction

  function automatic logic [IM_W-1:0] put_m(input logic [IM_W-1:0] v, input int lane, input int val);
    v[(N_LANE-lane)*MAN_W +: MAN_W] = MAN_W'(val);
    return v;
  endfunction

  // Reference: value of man * 2^GRD_W divided by 2^diff, with any nonzero
  // remainder forced into the LSB, then negated modulo 2^ALN_W if signed.
  function automatic logic [ALN_W-1:0] ref_lane(input longint man, input bit neg, input int diff);
    longint ext, q, dv;
    ext = man * (2 ** GRD_W);
    if (diff >= MAN_W + GRD_W) begin
      q = (man != 0) ? 1 : 0;
    end else begin
      dv = longint'(2) ** diff;
      q  = ext / dv;
      if (ext % dv != 0) q = q | 1;
    end
    if (neg) q = (longint'(1) << ALN_W) - q;
    return ALN_W'(q);
  endfunction

  task automatic model_push();
    int               ex [N_LANE];
    longint           mn [N_LANE];
    bit               ng [N_LANE];
    int               mx;
    logic [OUT_W-1:0] v;
    mx = 0;
    v  = '0;
    for (int i = 0; i < N_LANE; i++) begin
      if (bus.in_skip[N_LANE-1-i]) begin
        ex[i] = 0;
        mn[i] = 0;
        ng[i] = 1'b0;
      end else begin
        ex[i] = int'(bus.in_exp[(N_LANE-1-i)*EXP_W +: EXP_W]);
        mn[i] = longint'(bus.in_man[(N_LANE-1-i)*MAN_W +: MAN_W]);
        ng[i] = bus.in_sign[N_LANE-1-i];
      end
      if (ex[i] > mx) mx = ex[i];
    end
    for (int i = 0; i < N_LANE; i++) begin
      v[(N_LANE-1-i)*ALN_W +: ALN_W] = ref_lane(mn[i], ng[i], mx - ex[i]);
    end
    exp_q.push_back(v);
    expe_q.push_back(EXP_W'(mx));
  endtask

  // Compare process: checks every output transfer and stall stability,
  // and feeds the model on every input transfer.
  logic [OUT_W-1:0] hold_al;
  logic [EXP_W-1:0] hold_e;
  bit               holding = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      expe_q.delete();
      holding = 1'b0;
    end else begin
      if (holding) begin
        chk("stall_valid", OUT_W'(bus.out_valid), OUT_W'(1));
        chk("stall_lanes", bus.out_aligned, hold_al);
        chk("stall_exp", OUT_W'(bus.out_max_exp), OUT_W'(hold_e));
      end
      holding = 1'b0;
      if (bus.out_valid) begin
        if (!bus.out_ready) begin
          holding = 1'b1;
          hold_al = bus.out_aligned;
          hold_e  = bus.out_max_exp;
        end else begin
          n_out++;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", OUT_W'(1), OUT_W'(0));
          end else begin
            chk("beat_exp", OUT_W'(bus.out_max_exp), OUT_W'(expe_q.pop_front()));
            chk("beat_lanes", bus.out_aligned, exp_q.pop_front());
          end
        end
      end
      if (bus.in_valid && bus.in_ready) model_push();
    end
  end

  task automatic rand_inputs();
    logic [IE_W-1:0]  ev;
    logic [IM_W-1:0]  mv;
    logic [EXP_W-1:0] base;
    base = EXP_W'($urandom_range(0, 63));
    for (int i = 0; i < N_LANE; i++) begin
      if ($urandom_range(0, 1) == 1)
        ev[i*EXP_W +: EXP_W] = EXP_W'($urandom_range(0, 63));
      else
        ev[i*EXP_W +: EXP_W] = base - EXP_W'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       mv[i*MAN_W +: MAN_W] = '0;
        1:       mv[i*MAN_W +: MAN_W] = MAN_W'($urandom_range(0, 15));
        default: mv[i*MAN_W +: MAN_W] = MAN_W'($urandom);
      endcase
    end
    bus.in_exp  = ev;
    bus.in_man  = mv;
    bus.in_sign = N_LANE'($urandom);
    case ($urandom_range(0, 7))
      0:       bus.in_skip = '1;
      1, 2:    bus.in_skip = N_LANE'($urandom) & N_LANE'($urandom);
      default: bus.in_skip = '0;
    endcase
  endtask

  // Drive one beat into an empty pipeline and leave the clock #1 after the
  // edge where it must appear on the output.
  task automatic push_one(input logic [N_LANE-1:0] skip, input logic [N_LANE-1:0] sign,
                          input logic [IE_W-1:0] ev, input logic [IM_W-1:0] mv);
    @(posedge clk); #1;
    bus.in_skip  = skip;
    bus.in_sign  = sign;
    bus.in_exp   = ev;
    bus.in_man   = mv;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("latency_not_early", OUT_W'(bus.out_valid), OUT_W'(0));
    @(posedge clk); #1;
    chk("latency_two", OUT_W'(bus.out_valid), OUT_W'(1));
  endtask

  initial begin
    #1_500_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [IE_W-1:0] ev;
    logic [IM_W-1:0] mv;
    int              n0, guard, sent, cyc;
    bit              f, stale, ok;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_skip   = '0;
    bus.in_sign   = '0;
    bus.in_exp    = '0;
    bus.in_man    = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset_out_valid", OUT_W'(bus.out_valid), OUT_W'(0));
    chk("reset_max_exp", OUT_W'(bus.out_max_exp), OUT_W'(0));
    chk("reset_aligned", bus.out_aligned, OUT_W'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", OUT_W'(bus.in_ready), OUT_W'(1));

    // Aligned lanes
    ev = '0; mv = '0;
    for (int l = 1; l <= N_LANE; l++) begin
      ev = put_e(ev, l, 15);
      mv = put_m(mv, l, 'h200000);
    end
    ev = put_e(ev, 2, 13);
    push_one('0, '0, ev, mv);
    chk("t1_max_exp", OUT_W'(bus.out_max_exp), OUT_W'(15));
    chk("t1_lane1", OUT_W'(lane_of(bus.out_aligned, 1)), OUT_W'(26'h1000000));
    chk("t1_lane2", OUT_W'(lane_of(bus.out_aligned, 2)), OUT_W'(26'h0400000));

    // Negation and sticky
    ev = '0; mv = '0;
    for (int l = 1; l <= N_LANE; l++) ev = put_e(ev, l, 35);
    ev = put_e(ev, 3, 30);
    ev = put_e(ev, 4, 5);
    mv = put_m(mv, 1, 'h200000);
    mv = put_m(mv, 3, 'h000001);
    mv = put_m(mv, 4, 'h3FFFFF);
    push_one('0, 9'h100, ev, mv);
    chk("t2_max_exp", OUT_W'(bus.out_max_exp), OUT_W'(35));
    chk("t2_lane1_neg", OUT_W'(lane_of(bus.out_aligned, 1)), OUT_W'(26'h3000000));
    chk("t2_lane2_zero", OUT_W'(lane_of(bus.out_aligned, 2)), OUT_W'(0));
    chk("t2_lane3_sticky", OUT_W'(lane_of(bus.out_aligned, 3)), OUT_W'(1));
    chk("t2_lane4_far", OUT_W'(lane_of(bus.out_aligned, 4)), OUT_W'(1));

    // Skip: everything skipped, then lane 1 only
    ev = '0; mv = '0;
    for (int l = 1; l <= N_LANE; l++) begin
      ev = put_e(ev, l, 20);
      mv = put_m(mv, l, 'h2ABCDE);
    end
    push_one(9'h1FF, 9'h1FF, ev, mv);
    chk("t3_all_skip_exp", OUT_W'(bus.out_max_exp), OUT_W'(0));
    chk("t3_all_skip_lanes", bus.out_aligned, OUT_W'(0));
    ev = '0; mv = '0;
    for (int l = 1; l <= N_LANE; l++) begin
      ev = put_e(ev, l, 10);
      mv = put_m(mv, l, 'h200000);
    end
    ev = put_e(ev, 1, 31);
    push_one(9'h100, '0, ev, mv);
    chk("t3_skip1_exp", OUT_W'(bus.out_max_exp), OUT_W'(10));
    chk("t3_skip1_lane1", OUT_W'(lane_of(bus.out_aligned, 1)), OUT_W'(0));
    chk("t3_skip1_lane2", OUT_W'(lane_of(bus.out_aligned, 2)), OUT_W'(26'h1000000));

    // Backpressure: 4 beats back to back, 3-cycle stall after the first output
    repeat (3) @(posedge clk);
    n0 = n_out;
    fork
      begin
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
          rand_inputs();
          bus.in_valid = 1'b1;
          guard = 0;
          do begin
            @(negedge clk);
            f = bus.in_ready;
            @(posedge clk); #1;
            guard++;
          end while (!f && guard < 50);
          if (!f) chk("bp_input_timeout", OUT_W'(0), OUT_W'(1));
        end
        bus.in_valid = 1'b0;
      end
      begin
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (!bus.out_valid && guard < 20);
        chk("bp_first_out", OUT_W'(bus.out_valid), OUT_W'(1));
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_low", OUT_W'(bus.in_ready), OUT_W'(0));
        chk("bp_out_valid_held", OUT_W'(bus.out_valid), OUT_W'(1));
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    guard = 0;
    while (n_out < n0 + 4 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    chk("bp_beat_count", OUT_W'(n_out - n0), OUT_W'(4));

    // Reset with two beats in flight
    @(posedge clk); #1;
    rand_inputs();
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    rand_inputs();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rst_inflight_valid", OUT_W'(bus.out_valid), OUT_W'(1));
    rst = 1'b1;
    #1;
    chk("rst_async_valid", OUT_W'(bus.out_valid), OUT_W'(0));
    chk("rst_async_exp", OUT_W'(bus.out_max_exp), OUT_W'(0));
    chk("rst_async_lanes", bus.out_aligned, OUT_W'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale = 1'b1;
    end
    chk("rst_no_stale", OUT_W'(stale), OUT_W'(0));
    chk("rst_in_ready", OUT_W'(bus.in_ready), OUT_W'(1));

    // Randomized traffic with random valid/ready
    sent = 0;
    cyc  = 0;
    @(posedge clk); #1;
    while (sent < 10000 && cyc < 60000) begin
      @(negedge clk);
      f = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (f) sent++;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid || f) begin
        if ($urandom_range(0, 3) != 0) begin
          rand_inputs();
          bus.in_valid = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    chk("rand_sent", OUT_W'(sent >= 10000), OUT_W'(1));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    ok    = 1'b0;
    while (!ok && guard < 20) begin
      @(posedge clk);
      guard++;
      ok = (exp_q.size() == 0);
    end
    repeat (2) @(posedge clk);
    chk("rand_drained", OUT_W'(exp_q.size()), OUT_W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
